// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern, length and overlap mode.
// Optional SEQ_DET_LAST_POS_EN adds last_pos, the bit index of the most recent match.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   cfg_load   latch pattern/pat_len/overlap; clears history and fill count
//   pattern    pattern[pat_len-1] is the first-received bit, pattern[0] the last
//   pat_len    number of active pattern bits (1..PAT_W)
//   overlap    1 = keep history after a match, 0 = restart after each match
//   en, din    qualified serial data bit
//   clr_cnt    synchronous clear of match_cnt (wins over an increment)
//   match      registered one-cycle match pulse
//   match_cnt  saturating match counter
//   cfg_err    latched configuration is invalid
//   last_pos   (SEQ_DET_LAST_POS_EN only) index of the bit that completed the last match
module seq_pattern_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
`ifdef SEQ_DET_LAST_POS_EN
  output logic             cfg_err,
  output logic [15:0]      last_pos
`else
  output logic             cfg_err
`endif
);

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_FILL  = 2'd1,
    S_HUNT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cfg_err;

  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_fill_nxt;
  logic             w_cfg_ok;
  logic             w_full;
  logic             w_hit;
  logic             w_match;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_cfg_ok   = (pat_len != '0) && (int'(pat_len) <= PAT_W);
  assign w_hist_nxt = {r_hist[PAT_W-2:0], din};
  assign w_fill_nxt = r_fill + LEN_W'(1);
  assign w_full     = (w_fill_nxt == r_len);
  // Compare against the post-shift history so the completing bit counts.
  assign w_hit      = ((w_hist_nxt ^ r_pat) & w_mask) == '0;
  assign w_match    = en && !cfg_load && w_hit &&
                      ((r_state == S_FILL && w_full) ||
                       (r_state == S_HUNT));

`ifdef SEQ_DET_LAST_POS_EN
  logic [15:0] r_idx;
  logic [15:0] r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_last <= '0;
    end else if (cfg_load) begin
      r_idx  <= '0;
    end else if (en && r_state != S_UNCFG) begin
      r_idx <= r_idx + 16'd1;
      if (w_match) begin
        r_last <= r_idx;
      end
    end
  end

  assign last_pos = r_last;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_UNCFG;
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_cfg_err <= 1'b1;
    end else begin
      r_match <= w_match;

      if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_match && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (cfg_load) begin
        r_pat     <= pattern;
        r_len     <= pat_len;
        r_ovl     <= overlap;
        r_hist    <= '0;
        r_fill    <= '0;
        r_cfg_err <= !w_cfg_ok;
        r_state   <= w_cfg_ok ? S_FILL : S_UNCFG;
      end else if (en) begin
        unique case (r_state)
          S_UNCFG: ;
          S_FILL: begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            if (w_full) begin
              r_state <= S_HUNT;
            end
          end
          S_HUNT: begin
            r_hist <= w_hist_nxt;
          end
          default: r_state <= S_UNCFG;
        endcase
        // Non-overlap mode restarts the window after every hit.
        if (w_match && !r_ovl) begin
          r_hist  <= '0;
          r_fill  <= '0;
          r_state <= S_FILL;
        end
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed testbench for seq_pattern_detector.
// Second instance with CNT_W = 2 covers counter saturation.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       overlap;
  logic       en;
  logic       din;
  logic       clr_cnt;
  logic       match;
  logic [7:0] match_cnt;
  logic       cfg_err;
  logic       match2;
  logic [1:0] cnt2;
  logic       err2;
`ifdef SEQ_DET_LAST_POS_EN
  logic [15:0] last_pos;
  logic [15:0] last_pos2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .en(en), .din(din),
    .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
`ifdef SEQ_DET_LAST_POS_EN
    .cfg_err(cfg_err), .last_pos(last_pos)
`else
    .cfg_err(cfg_err)
`endif
  );

  seq_pattern_detector #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .en(en), .din(din),
    .clr_cnt(clr_cnt), .match(match2), .match_cnt(cnt2),
`ifdef SEQ_DET_LAST_POS_EN
    .cfg_err(err2), .last_pos(last_pos2)
`else
    .cfg_err(err2)
`endif
  );

  task automatic bit_in(input logic e, input logic d);
    en  = e;
    din = d;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic e, input logic d);
    cfg_load = 1'b1;
    clr_cnt  = 1'b1;
    pattern  = p;
    pat_len  = l;
    overlap  = o;
    en       = e;
    din      = d;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
    clr_cnt  = 1'b0;
    en       = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL reset_match got %b exp 0", match);
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", match_cnt);
    end
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL reset_cfg_err got %b exp 1", cfg_err);
    end
`ifdef SEQ_DET_LAST_POS_EN
    checks++;
    if (last_pos !== 16'd0) begin
      errors++; $display("FAIL reset_last_pos got %0d exp 0", last_pos);
    end
`endif
    // Bits before any configuration are ignored.
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1, 1'b1);
      checks++;
      if (match !== 1'b0) begin
        errors++; $display("FAIL uncfg_match bit %0d got %b exp 0", i, match);
      end
    end
  endtask

  task automatic test_overlap;
    logic [6:0] s;
    logic [6:0] exp;
    s   = 7'b1101101;
    exp = 7'b1001000;
    cfg(8'b00001011, 4'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL ovl_cfg_err got %b exp 0", cfg_err);
    end
    for (int i = 0; i < 7; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== exp[i]) begin
        errors++; $display("FAIL ovl_match bit %0d got %b exp %b", i, match, exp[i]);
      end
`ifdef SEQ_DET_LAST_POS_EN
      if (exp[i]) begin
        checks++;
        if (last_pos !== 16'(i)) begin
          errors++; $display("FAIL ovl_last_pos got %0d exp %0d", last_pos, i);
        end
      end
`endif
    end
    checks++;
    if (match_cnt !== 8'd2) begin
      errors++; $display("FAIL ovl_cnt got %0d exp 2", match_cnt);
    end
  endtask

  task automatic test_no_overlap;
    logic [6:0] s;
    logic [6:0] exp;
    s   = 7'b1101101;
    exp = 7'b0001000;
    cfg(8'b00001011, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== exp[i]) begin
        errors++; $display("FAIL novl_match bit %0d got %b exp %b", i, match, exp[i]);
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      errors++; $display("FAIL novl_cnt got %0d exp 1", match_cnt);
    end
  endtask

  task automatic test_gaps;
    logic [3:0] s;
    s = 4'b1101;
    cfg(8'b00001011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== (i == 3)) begin
        errors++; $display("FAIL gap_match bit %0d got %b exp %b", i, match, (i == 3));
      end
      for (int g = 0; g < 3; g++) begin
        bit_in(1'b0, 1'b1);
        checks++;
        if (match !== 1'b0) begin
          errors++; $display("FAIL gap_idle bit %0d gap %0d got %b exp 0", i, g, match);
        end
      end
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      errors++; $display("FAIL gap_cnt got %0d exp 1", match_cnt);
    end
  endtask

  task automatic test_saturate;
    logic [1:0] exp;
    cfg(8'b00000001, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      bit_in(1'b1, 1'b1);
      checks++;
      if (match2 !== 1'b1 || cnt2 !== exp) begin
        errors++;
        $display("FAIL sat_cnt bit %0d got m=%b c=%0d exp m=1 c=%0d", i, match2, cnt2, exp);
      end
    end
    clr_cnt = 1'b1;
    bit_in(1'b1, 1'b1);
    clr_cnt = 1'b0;
    checks++;
    if (match2 !== 1'b1 || cnt2 !== 2'd0) begin
      errors++; $display("FAIL sat_clr got m=%b c=%0d exp m=1 c=0", match2, cnt2);
    end
  endtask

  task automatic test_cfg_err;
    logic [7:0] s;
    s = 8'b11011101;
    cfg(8'b00001011, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL len0_cfg_err got %b exp 1", cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== 1'b0) begin
        errors++; $display("FAIL len0_match bit %0d got %b exp 0", i, match);
      end
    end
    cfg(8'b00001011, 4'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL len9_cfg_err got %b exp 1", cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== 1'b0) begin
        errors++; $display("FAIL len9_match bit %0d got %b exp 0", i, match);
      end
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      errors++; $display("FAIL len9_cnt got %0d exp 0", match_cnt);
    end
    cfg(8'b00001011, 4'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL len4_cfg_err got %b exp 0", cfg_err);
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] s;
    s = 3'b101;
    cfg(8'b00001011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b1, s[i]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cfg_err !== 1'b1 || match_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_async got err=%b cnt=%0d exp err=1 cnt=0", cfg_err, match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    bit_in(1'b1, 1'b1);
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL rst_mid_match got %b exp 0", match);
    end
  endtask

  task automatic test_cfg_drop;
    logic [2:0] s;
    s = 3'b101;
    cfg(8'b00001011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b1, s[i]);
    end
    cfg(8'b00001011, 4'd4, 1'b1, 1'b1, 1'b1);
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL drop_match got %b exp 0", match);
    end
    // 0,1,1 would complete 1011 if stale history or fill count survived.
    s = 3'b110;
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b1, s[i]);
      checks++;
      if (match !== 1'b0) begin
        errors++; $display("FAIL drop_hist bit %0d got %b exp 0", i, match);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    cfg_load = 1'b0;
    pattern  = '0;
    pat_len  = '0;
    overlap  = 1'b0;
    en       = 1'b0;
    din      = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_overlap;
    test_no_overlap;
    test_gaps;
    test_saturate;
    test_cfg_err;
    test_reset_mid;
    test_cfg_drop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 1011 Moore detector.
- Pattern, pattern length and overlap mode are runtime-configurable.
- Adds a qualified bit-valid input, a saturating match counter and a configuration-error flag.
- Sits on serial control/run lines and flags when a programmed bit sequence has been received.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of pat_len; must hold the value PAT_W.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  latch pattern/pat_len/overlap into internal config registers; clears history.
- pattern  in  PAT_W  pattern; pattern[pat_len-1] is the first-received bit, pattern[0] the last.
- pat_len  in  LEN_W  number of active pattern bits.
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- en  in  1  din is valid this cycle.
- din  in  1  serial data bit.
- clr_cnt  in  1  synchronous clear of match_cnt.
- match  out  1  one-cycle pulse, registered.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  latched config is invalid (pat_len = 0 or pat_len > PAT_W).

Behaviour:
- Reset (async): config regs = 0, history = 0, fill count = 0, state = UNCFG, match = 0, match_cnt = 0, cfg_err = 1.
- State machine:
  - UNCFG: entered at reset. Bits ignored. cfg_load with valid config -> FILL; invalid config -> UNCFG with cfg_err = 1.
  - FILL: each en cycle shifts din into history LSB and increments fill count. When fill count reaches pat_len -> HUNT.
  - HUNT: each en cycle shifts history; compare is done on the post-shift low pat_len bits.
  - cfg_load from any state: reloads config, clears history and fill count, goes to FILL or UNCFG per validity.
- Match timing:
  - Condition: en with din completes a window equal to the pattern.
  - match = 1 in the following cycle, exactly 1 cycle wide; one match per en bit max.
  - The bit that completes the pattern fills the count to pat_len; the check counts it, so the FILL-to-HUNT transition cycle can itself match.
- Overlap:
  - overlap = 1: history kept after a match; stay in HUNT.
  - overlap = 0: fill count and history cleared after a match; -> FILL.
- match_cnt:
  - +1 per match, saturates at all-ones (no wrap).
  - clr_cnt concurrent with a match: cleared result is 0 (clear wins).
- Precedence: cfg_load in the same cycle as en drops that bit; cfg_load wins over everything except reset.
- en = 0 cycles: no shift, no state change, match = 0.
- Bits beyond pat_len in pattern are ignored.
- cfg_err is updated only on cfg_load (or reset).
- Reset mid-stream: immediate return to reset values; a match pulse in flight is lost.

Optional Feature:
- Macro SEQ_DET_LAST_POS_EN.
- When defined:
  - Adds a BIT_IDX_W = 16 wrapping counter of accepted en bits, cleared by reset and cfg_load.
  - Adds output last_pos [15:0]: index of the bit that completed the most recent match (first accepted bit = 0). Updated in the same cycle match rises; reset value 0.
- When undefined: no counter, no last_pos port; all other behaviour identical.

Test Plan:
- pattern = 8'b00001011, pat_len = 4, overlap = 1; en = 1; stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt = 2; last_pos = 3 then 6 (if enabled).
- Same stream with overlap = 0 -> single match after bit 4; match_cnt = 1.
- Same config; stream 1,0,1,1 with en low for 3 cycles between each bit -> exactly one match, one cycle after the 4th en cycle; no pulses during gaps.
- CNT_W = 2, pat_len = 1, pattern bit0 = 1; five 1-bits -> match_cnt 1,2,3,3,3. Then clr_cnt with a simultaneous match -> match_cnt = 0.
- cfg_load with pat_len = 0, then with pat_len = 9 (PAT_W = 8) -> cfg_err = 1, no matches on any stream. cfg_load with pat_len = 4 -> cfg_err = 0.
- Stream 1,0,1 then reset pulse, then 1 -> no match. Also cfg_load asserted with en on 4th bit of 1011 -> bit dropped, no match, history empty.
